// File: rtl/way_pkg.sv
// way_pkg: shared definitions for the way_bank cache-way slice.
//   state_t       : controller states (IDLE, ACCESS, RESP, SWEEP)
//   op_t          : access operation, encoded as {cmp, write}
//   *_DEF         : default parameter values used by way_bank and way_line_store
package way_pkg;

  localparam int unsigned TAG_W_DEF  = 5;
  localparam int unsigned WORD_W_DEF = 16;
  localparam int unsigned WORDS_DEF  = 4;
  localparam int unsigned SETS_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    SWEEP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    READ      = 2'b00,
    FILL      = 2'b01,
    CMP_READ  = 2'b10,
    CMP_WRITE = 2'b11
  } op_t;

endpackage

// File: rtl/way_line_store.sv
// way_line_store: per-set tag/valid/dirty storage and per-word data storage for
// one cache way. One synchronous write port with per-field write enables and one
// asynchronous read port. Contents are not reset; the owner clears valid/dirty
// by sweeping.
//
// Optional build macro: WAY_BANK_PARITY_EN adds one even-parity bit per word,
// computed on every data write and returned on rd_par.
//
// Ports:
//   clk                         rising-edge clock
//   we_tag/we_data/we_valid/we_dirty  field write enables
//   wr_index, wr_word           write address (set, word)
//   wr_tag, wr_data             tag / word write values
//   wr_valid, wr_dirty          valid / dirty write values
//   rd_index, rd_word           read address (set, word)
//   rd_tag, rd_data             stored tag / selected word
//   rd_valid, rd_dirty          stored valid / dirty bits
//   rd_par                      stored parity of selected word (parity build only)
module way_line_store
  import way_pkg::*;
#(
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned WORDS  = WORDS_DEF,
  parameter int unsigned SETS   = SETS_DEF
) (
  input  logic                       clk,
  input  logic                       we_tag,
  input  logic                       we_data,
  input  logic                       we_valid,
  input  logic                       we_dirty,
  input  logic [$clog2(SETS)-1:0]    wr_index,
  input  logic [$clog2(WORDS)-1:0]   wr_word,
  input  logic [TAG_W-1:0]           wr_tag,
  input  logic [WORD_W-1:0]          wr_data,
  input  logic                       wr_valid,
  input  logic                       wr_dirty,
  input  logic [$clog2(SETS)-1:0]    rd_index,
  input  logic [$clog2(WORDS)-1:0]   rd_word,
  output logic [TAG_W-1:0]           rd_tag,
  output logic [WORD_W-1:0]          rd_data,
  output logic                       rd_valid,
  output logic                       rd_dirty
`ifdef WAY_BANK_PARITY_EN
  ,
  output logic                       rd_par
`endif
);

  logic [TAG_W-1:0]  tag_mem   [SETS];
  logic              valid_mem [SETS];
  logic              dirty_mem [SETS];
  logic [WORD_W-1:0] data_mem  [SETS][WORDS];
`ifdef WAY_BANK_PARITY_EN
  logic              par_mem   [SETS][WORDS];
`endif

  always_ff @(posedge clk) begin
    if (we_tag)   tag_mem[wr_index]   <= wr_tag;
    if (we_valid) valid_mem[wr_index] <= wr_valid;
    if (we_dirty) dirty_mem[wr_index] <= wr_dirty;
    if (we_data)  data_mem[wr_index][wr_word] <= wr_data;
  end

`ifdef WAY_BANK_PARITY_EN
  // Even parity: stored bit makes the XOR of word and parity zero.
  always_ff @(posedge clk) begin
    if (we_data) par_mem[wr_index][wr_word] <= ^wr_data;
  end

  assign rd_par = par_mem[rd_index][rd_word];
`endif

  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_mem[rd_index];
  assign rd_dirty = dirty_mem[rd_index];
  assign rd_data  = data_mem[rd_index][rd_word];

endmodule

// File: rtl/way_bank.sv
// way_bank: one way of a set-associative cache. Accepts four-phase access
// requests (read, fill, compare-read, compare-write) and flush requests that
// invalidate every set with a one-set-per-cycle sweep. Reset also runs a sweep,
// which returns to IDLE without acknowledging.
//
// Optional build macro: WAY_BANK_PARITY_EN adds per-word parity storage and the
// parity_err output.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   enable          access request (level, held until ack, released after)
//   flush           invalidate-all request (level, held until ack)
//   cmp, write      operation select {cmp,write}
//   index, word     set and word select
//   tag, data_in    request tag and write data
//   valid_in        valid bit stored by a fill
//   hit             compare hit (RESP only)
//   dirty, valid    line dirty / valid bits (post-write)
//   tag_out         stored tag (post-write)
//   data_out        selected word (post-write)
//   ack             request complete (RESP)
//   busy            sweep in progress
//   parity_err      selected word failed parity check (parity build, RESP only)
module way_bank
  import way_pkg::*;
#(
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned WORD_W = WORD_W_DEF,
  parameter int unsigned WORDS  = WORDS_DEF,
  parameter int unsigned SETS   = SETS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     cmp,
  input  logic                     write,
  input  logic [$clog2(SETS)-1:0]  index,
  input  logic [$clog2(WORDS)-1:0] word,
  input  logic [TAG_W-1:0]         tag,
  input  logic [WORD_W-1:0]        data_in,
  input  logic                     valid_in,
  output logic                     hit,
  output logic                     dirty,
  output logic                     valid,
  output logic [TAG_W-1:0]         tag_out,
  output logic [WORD_W-1:0]        data_out,
  output logic                     ack,
  output logic                     busy
`ifdef WAY_BANK_PARITY_EN
  ,
  output logic                     parity_err
`endif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned WRD_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

  state_t state_q, state_d;

  // Captured request
  logic [IDX_W-1:0]  idx_q;
  logic [WRD_W-1:0]  wrd_q;
  logic [TAG_W-1:0]  tag_q;
  logic [WORD_W-1:0] data_q;
  logic              vin_q;
  op_t               op_q;

  logic [IDX_W-1:0]  cnt_q;
  logic              rst_sweep_q;   // current sweep was started by reset
  logic              resp_sweep_q;  // current RESP acknowledges a flush
  logic              hit_q;

  // Store interface
  logic              we_tag, we_data, we_valid, we_dirty;
  logic [IDX_W-1:0]  wr_index;
  logic              wr_valid, wr_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [WORD_W-1:0] rd_data;
  logic              rd_valid, rd_dirty;
`ifdef WAY_BANK_PARITY_EN
  logic              rd_par;
  logic              perr_q;
`endif

  logic hit_now;
  logic word_write;

  way_line_store #(
    .TAG_W (TAG_W),
    .WORD_W(WORD_W),
    .WORDS (WORDS),
    .SETS  (SETS)
  ) u_store (
    .clk     (clk),
    .we_tag  (we_tag),
    .we_data (we_data),
    .we_valid(we_valid),
    .we_dirty(we_dirty),
    .wr_index(wr_index),
    .wr_word (wrd_q),
    .wr_tag  (tag_q),
    .wr_data (data_q),
    .wr_valid(wr_valid),
    .wr_dirty(wr_dirty),
    .rd_index(idx_q),
    .rd_word (wrd_q),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty)
`ifdef WAY_BANK_PARITY_EN
    ,
    .rd_par  (rd_par)
`endif
  );

  // Compare result against the pre-write line contents.
  assign hit_now    = op_q[1] && rd_valid && (rd_tag == tag_q);
  assign word_write = (op_q == FILL) || ((op_q == CMP_WRITE) && hit_now);

  always_comb begin
    state_d  = state_q;
    we_tag   = 1'b0;
    we_data  = 1'b0;
    we_valid = 1'b0;
    we_dirty = 1'b0;
    wr_index = idx_q;
    wr_valid = 1'b0;
    wr_dirty = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable)     state_d = ACCESS;
        else if (flush) state_d = SWEEP;
      end
      ACCESS: begin
        state_d = RESP;
        if (op_q == FILL) begin
          we_tag   = 1'b1;
          we_data  = 1'b1;
          we_valid = 1'b1;
          we_dirty = 1'b1;
          wr_valid = vin_q;
          wr_dirty = 1'b0;
        end else if ((op_q == CMP_WRITE) && hit_now) begin
          we_data  = 1'b1;
          we_dirty = 1'b1;
          wr_dirty = 1'b1;
        end
      end
      RESP: begin
        if (resp_sweep_q ? !flush : !enable) state_d = IDLE;
      end
      SWEEP: begin
        wr_index = cnt_q;
        we_valid = 1'b1;
        we_dirty = 1'b1;
        if (cnt_q == LAST_SET) state_d = rst_sweep_q ? IDLE : RESP;
      end
      default: state_d = IDLE;
    endcase

    // Reset discards whatever write the current state would have made.
    if (rst) begin
      we_tag   = 1'b0;
      we_data  = 1'b0;
      we_valid = 1'b0;
      we_dirty = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SWEEP;
      cnt_q        <= '0;
      rst_sweep_q  <= 1'b1;
      resp_sweep_q <= 1'b0;
      hit_q        <= 1'b0;
      dirty        <= 1'b0;
      valid        <= 1'b0;
      tag_out      <= '0;
      data_out     <= '0;
      idx_q        <= '0;
      wrd_q        <= '0;
      tag_q        <= '0;
      data_q       <= '0;
      vin_q        <= 1'b0;
      op_q         <= READ;
`ifdef WAY_BANK_PARITY_EN
      perr_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (enable) begin
            idx_q  <= index;
            wrd_q  <= word;
            tag_q  <= tag;
            data_q <= data_in;
            vin_q  <= valid_in;
            op_q   <= op_t'({cmp, write});
          end else if (flush) begin
            cnt_q       <= '0;
            rst_sweep_q <= 1'b0;
          end
        end
        ACCESS: begin
          // Outputs are latched with the values the line holds after this write.
          resp_sweep_q <= 1'b0;
          hit_q        <= hit_now;
          tag_out      <= (op_q == FILL) ? tag_q : rd_tag;
          data_out     <= word_write ? data_q : rd_data;
          valid        <= (op_q == FILL) ? vin_q : rd_valid;
          dirty        <= (op_q == FILL) ? 1'b0 : (word_write ? 1'b1 : rd_dirty);
`ifdef WAY_BANK_PARITY_EN
          perr_q       <= word_write ? 1'b0 : ((^rd_data) ^ rd_par);
`endif
        end
        RESP: begin
          if (state_d == IDLE) begin
            hit_q <= 1'b0;
`ifdef WAY_BANK_PARITY_EN
            perr_q <= 1'b0;
`endif
          end
        end
        SWEEP: begin
          if (cnt_q != LAST_SET) cnt_q <= cnt_q + 1'b1;
          else                   resp_sweep_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign hit  = hit_q;
  assign ack  = (state_q == RESP);
  assign busy = (state_q == SWEEP);
`ifdef WAY_BANK_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_way_bank.sv
// tb_way_bank: directed and randomized stimulus for way_bank, checked against a
// behavioural array model of the way's contents.
module tb_way_bank;

  localparam int unsigned SETS  = 8;
  localparam int unsigned WORDS = 4;

  logic        clk = 1'b0;
  logic        rst, enable, flush, cmp, write, valid_in;
  logic [2:0]  index;
  logic [1:0]  word;
  logic [4:0]  tag;
  logic [15:0] data_in;
  logic        hit, dirty, valid, ack, busy;
  logic [4:0]  tag_out;
  logic [15:0] data_out;
`ifdef WAY_BANK_PARITY_EN
  logic        parity_err;
`endif

  int checks = 0;
  int failures = 0;

  // Behavioural model of the way contents
  logic [4:0]  m_tag   [SETS];
  logic [15:0] m_data  [SETS][WORDS];
  bit          m_valid [SETS];
  bit          m_dirty [SETS];
  bit          m_tag_k [SETS];
  bit          m_data_k[SETS][WORDS];

  bit          got_hit;
  int          nb;

  always #5 clk = ~clk;

  way_bank #(.TAG_W(5), .WORD_W(16), .WORDS(4), .SETS(8)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .cmp(cmp), .write(write),
    .index(index), .word(word), .tag(tag), .data_in(data_in), .valid_in(valid_in),
    .hit(hit), .dirty(dirty), .valid(valid), .tag_out(tag_out), .data_out(data_out),
    .ack(ack), .busy(busy)
`ifdef WAY_BANK_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = 0;
      m_dirty[s] = 0;
    end
  endtask

  // Counts consecutive busy samples, starting with the current one (bounded).
  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      n++;
      step();
    end
  endtask

  task automatic check_lines(input string pfx, input int s, input int w, input bit exp_hit);
    chk({pfx, "_hit"}, hit, exp_hit);
    chk({pfx, "_valid"}, valid, m_valid[s]);
    chk({pfx, "_dirty"}, dirty, m_dirty[s]);
    if (m_tag_k[s])     chk({pfx, "_tag"}, tag_out, m_tag[s]);
    if (m_data_k[s][w]) chk({pfx, "_data"}, data_out, m_data[s][w]);
  endtask

  // One complete four-phase access, starting and ending in IDLE.
  task automatic access(input bit c, input bit w, input int i, input int wd,
                        input logic [4:0] t, input logic [15:0] d, input bit vin,
                        input int hold, output bit obs_hit);
    bit h;
    h = c && m_valid[i] && (m_tag[i] == t);
    if (!c && w) begin
      m_tag[i] = t; m_tag_k[i] = 1;
      m_data[i][wd] = d; m_data_k[i][wd] = 1;
      m_valid[i] = vin; m_dirty[i] = 0;
    end else if (c && w && h) begin
      m_data[i][wd] = d; m_data_k[i][wd] = 1;
      m_dirty[i] = 1;
    end
    cmp = c; write = w; index = 3'(i); word = 2'(wd);
    tag = t; data_in = d; valid_in = vin; enable = 1'b1;
    step();
    chk("ack_early", ack, 1'b0);
    step();
    chk("ack", ack, 1'b1);
    obs_hit = hit;
    check_lines("resp", i, wd, h);
`ifdef WAY_BANK_PARITY_EN
    if (!c && w) chk("perr_fill", parity_err, 1'b0);
`endif
    // Request inputs may change while RESP holds its outputs.
    data_in = 16'($urandom); tag = 5'($urandom);
    for (int k = 0; k < hold; k++) begin
      step();
      chk("ack_hold", ack, 1'b1);
      check_lines("hold", i, wd, h);
    end
    enable = 1'b0;
    step();
    chk("ack_drop", ack, 1'b0);
    check_lines("idle", i, wd, 1'b0);
  endtask

  task automatic do_flush(input int hold);
    flush = 1'b1;
    step();
    count_busy(nb);
    chk("flush_busy_cycles", nb, 8);
    chk("flush_ack", ack, 1'b1);
    chk("flush_hit", hit, 1'b0);
    model_clear();
    for (int k = 0; k < hold; k++) begin
      step();
      chk("flush_ack_hold", ack, 1'b1);
    end
    flush = 1'b0;
    step();
    chk("flush_ack_drop", ack, 1'b0);
  endtask

  initial begin
    int op, i, wd;
    logic [4:0] t;
    rst = 1'b1; enable = 1'b0; flush = 1'b0; cmp = 1'b0; write = 1'b0;
    index = '0; word = '0; tag = '0; data_in = '0; valid_in = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      m_tag_k[s] = 0;
      for (int w = 0; w < WORDS; w++) m_data_k[s][w] = 0;
    end
    model_clear();

    // Reset state
    step();
    chk("rst_ack", ack, 1'b0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_dirty", dirty, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_tag", tag_out, 5'd0);
    chk("rst_data", data_out, 16'd0);
    chk("rst_busy", busy, 1'b1);
`ifdef WAY_BANK_PARITY_EN
    chk("rst_perr", parity_err, 1'b0);
`endif
    rst = 1'b0;
    count_busy(nb);
    chk("rst_busy_cycles", nb, 8);
    chk("rst_sweep_noack", ack, 1'b0);

    // Fill, compare-read hit/miss, compare-write, read
    access(0, 1, 2, 3, 5'b11101, 16'h0f0f, 1, 0, got_hit);
    chk("fill_tag", tag_out, 5'b11101);
    chk("fill_data", data_out, 16'h0f0f);
    chk("fill_hit", got_hit, 1'b0);
    access(1, 0, 2, 3, 5'b11101, 16'h0000, 0, 1, got_hit);
    chk("cmprd_hit", got_hit, 1'b1);
    chk("cmprd_data", data_out, 16'h0f0f);
    access(1, 0, 2, 3, 5'b00001, 16'h0000, 0, 0, got_hit);
    chk("cmprd_miss", got_hit, 1'b0);
    chk("cmprd_miss_valid", valid, 1'b1);
    access(1, 1, 2, 1, 5'b11101, 16'hbeef, 0, 0, got_hit);
    chk("cmpwr_hit", got_hit, 1'b1);
    chk("cmpwr_dirty", dirty, 1'b1);
    access(0, 0, 2, 1, 5'b00000, 16'h0000, 0, 0, got_hit);
    chk("rd_data", data_out, 16'hbeef);
    chk("rd_dirty", dirty, 1'b1);
    // Compare-write miss leaves the line untouched
    access(1, 1, 2, 1, 5'b00011, 16'h1234, 0, 0, got_hit);
    chk("cmpwr_miss_data", data_out, 16'hbeef);

`ifdef WAY_BANK_PARITY_EN
    access(0, 0, 2, 3, 5'b00000, 16'h0000, 0, 0, got_hit);
    chk("perr_clean", parity_err, 1'b0);
    u_dut.u_store.data_mem[2][3] = 16'h0f0e;
    m_data[2][3] = 16'h0f0e;
    cmp = 1'b0; write = 1'b0; index = 3'd2; word = 2'd3; enable = 1'b1;
    step(); step();
    chk("perr_flip", parity_err, 1'b1);
    enable = 1'b0;
    step();
    chk("perr_idle", parity_err, 1'b0);
`endif

    // Flush with an enable raised mid-sweep: it must wait for the flush handshake
    flush = 1'b1;
    step();
    cmp = 1'b1; write = 1'b0; index = 3'd2; word = 2'd3; tag = 5'b11101; enable = 1'b1;
    count_busy(nb);
    chk("stall_busy_cycles", nb, 8);
    chk("stall_flush_ack", ack, 1'b1);
    model_clear();
    flush = 1'b0;
    step();
    chk("stall_idle_ack", ack, 1'b0);
    step();
    chk("stall_access_ack", ack, 1'b0);
    step();
    chk("stall_resp_ack", ack, 1'b1);
    chk("flushed_hit", hit, 1'b0);
    chk("flushed_valid", valid, 1'b0);
    chk("flushed_dirty", dirty, 1'b0);
    enable = 1'b0;
    step();

    // Reset during the ACCESS cycle of a fill discards it
    cmp = 1'b0; write = 1'b1; index = 3'd5; word = 2'd0; tag = 5'b10101;
    data_in = 16'h5555; valid_in = 1'b1; enable = 1'b1;
    step();
    rst = 1'b1; enable = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_ack", ack, 1'b0);
    count_busy(nb);
    chk("midrst_busy_cycles", nb, 8);
    chk("midrst_noack", ack, 1'b0);
    model_clear();
    access(1, 0, 5, 0, 5'b10101, 16'h0000, 0, 0, got_hit);
    chk("midrst_hit", got_hit, 1'b0);

    // Randomized traffic against the model
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 14) == 0) begin
        do_flush(int'($urandom_range(0, 2)));
      end else begin
        op = int'($urandom_range(0, 3));
        i  = int'($urandom_range(0, SETS - 1));
        wd = int'($urandom_range(0, WORDS - 1));
        t  = 5'($urandom);
        if (m_tag_k[i] && $urandom_range(0, 2) != 0) t = m_tag[i];
        access(op[1], op[0], i, wd, t, 16'($urandom), $urandom_range(0, 3) != 0,
               int'($urandom_range(0, 2)), got_hit);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/way_bank.md
WAY_BANK -- requirements
Module: way_bank

Interface
REQ-001 Parameters (name, default, meaning):
- TAG_W, 5: tag width.
- WORD_W, 16: data word width.
- WORDS, 4: words per line, power of 2.
- SETS, 8: lines (sets) in this way, power of 2.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- enable, in, 1: access request, level, four-phase.
- flush, in, 1: invalidate-all request, level, four-phase.
- cmp, in, 1: compare mode.
- write, in, 1: write mode.
- index, in, clog2(SETS): set select.
- word, in, clog2(WORDS): word select.
- tag, in, TAG_W: request tag.
- data_in, in, WORD_W: write data.
- valid_in, in, 1: valid bit written by an access write.
- hit, out, 1: compare result.
- dirty, out, 1: line dirty bit.
- valid, out, 1: line valid bit.
- tag_out, out, TAG_W: stored tag.
- data_out, out, WORD_W: selected word.
- ack, out, 1: request complete.
- busy, out, 1: flush sweep in progress.

Function
REQ-003 FSM states: IDLE, ACCESS, RESP, SWEEP; encoding lives in the shared package.
REQ-004 Request acceptance:
- IDLE with enable=1 captures index, word, tag, data_in, valid_in, cmp, write, then goes to ACCESS.
- flush=1 in IDLE goes to SWEEP.
- enable takes priority when enable and flush are both 1.
REQ-005 ACCESS lasts one cycle. Per {cmp,write}:
- 00 read: present the line.
- 01 fill: store tag, store word, valid=valid_in, dirty=0.
- 10 compare-read: hit=valid AND tag match.
- 11 compare-write: on hit, store word and set dirty=1; on miss, no state change.
REQ-006 RESP asserts ack and holds hit, dirty, valid, tag_out, data_out stable. The block leaves RESP for IDLE on the first cycle enable is 0 (flush is 0 for a sweep response). Ack first rises 2 cycles after enable is sampled high.
REQ-007 Outputs are post-write values. A fill reports the written tag and data with hit=0. A compare-write hit reports dirty=1.
REQ-008 SWEEP:
- Clears valid and dirty of one set per cycle, starting at set 0.
- Takes SETS cycles with busy=1, then goes to RESP and asserts ack.
- enable is ignored during SWEEP.
REQ-009 The sweep counter is clog2(SETS) bits and stops at SETS-1 without wrap. Tag and data arrays are not cleared.
REQ-010 An enable asserted while busy=1 stalls until the sweep ack handshake completes.
REQ-011 Outside RESP: hit=0 and ack=0; data_out, tag_out, valid and dirty keep their last value.

Reset
REQ-012 rst has priority over every input. On rst: FSM enters SWEEP at set 0, ack=0, hit=0, dirty=0, valid=0, tag_out=0, data_out=0, busy=1.
REQ-013 A reset-initiated sweep ends in IDLE without ack. rst asserted mid-access or mid-sweep discards the operation and restarts the sweep at set 0.

Configuration
REQ-014 WAY_BANK_PARITY_EN defined:
- One even-parity bit is stored per word, computed on every word write.
- Output parity_err (1 bit) is asserted in RESP when the selected word's stored parity mismatches; it is 0 elsewhere and after reset.
REQ-015 WAY_BANK_PARITY_EN undefined: no parity storage and no parity_err port.

Structure
REQ-016 Package way_pkg holds:
- The state enum.
- The op encoding {cmp,write}: READ, FILL, CMP_READ, CMP_WRITE.
- Default parameter constants.
REQ-017 Sub-module way_line_store holds the tag, valid, dirty and data arrays (plus parity if enabled), with one write port and one asynchronous read port. way_bank contains the FSM and sweep counter.

Verification
REQ-018 After the reset sweep: fill index=2, word=3, tag=5'b11101, data=16'h0f0f, valid_in=1 -> ack at cycle 2, tag_out=11101, data_out=0f0f, valid=1, dirty=0, hit=0.
REQ-019 Compare-read index=2, word=3, tag=11101 -> hit=1, data_out=0f0f. The same with tag=00001 -> hit=0, valid=1.
REQ-020 Compare-write index=2, word=1, tag=11101, data=16'hbeef -> hit=1, dirty=1. A following read of word 1 -> data_out=beef, dirty=1.
REQ-021 flush=1 -> busy for exactly 8 cycles, then ack; flush low -> IDLE. A compare-read of index=2 then gives hit=0, valid=0, dirty=0.
REQ-022 rst pulsed in the ACCESS cycle of a fill to index=5 -> no ack, busy 8 cycles. Afterwards a compare-read of index=5 gives hit=0.
REQ-023 WAY_BANK_PARITY_EN: normal fill then read -> parity_err=0. Force one stored data bit at index=2, word=3, then read -> parity_err=1.
